// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer: FSM states,
// level count and the processor-priority mask.
package intr_pkg;

    localparam int NUM_LEVELS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // Bits strictly above the processor priority; level 7 masks everything.
    function automatic logic [NUM_LEVELS-1:0] ipl_mask(input logic [2:0] ipl);
        logic [3:0] sh;
        sh = {1'b0, ipl} + 4'd1;
        return {NUM_LEVELS{1'b1}} << sh;
    endfunction

endpackage

// File: rtl/intr_prio_encoder.sv
// Combinational arbiter: highest bus request strictly above the processor
// priority, as a one-hot grant, an any-above flag and a 3-bit level index.
module intr_prio_encoder
    import intr_pkg::*;
(
    input  logic [2:0]            i_ipl,
    input  logic [NUM_LEVELS-1:0] i_br,
    output logic [NUM_LEVELS-1:0] o_onehot,
    output logic                  o_any,
    output logic [2:0]            o_index
);

    logic [NUM_LEVELS-1:0] w_hot;

    assign w_hot = i_br & ipl_mask(i_ipl);
    assign o_any = |w_hot;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_index  = 3'd0;
        o_onehot = '0;
        // Ascending scan: the last hit is the highest level.
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (w_hot[i]) begin
                o_index = 3'(i);
            end
        end
        if (o_any) begin
            o_onehot[o_index] = 1'b1;
        end
    end

endmodule

// File: rtl/intr_sequencer.sv
// Interrupt acknowledge sequencer: grants one bus-request level at an
// instruction boundary, collects the device vector and presents it to the CPU.
module intr_sequencer
    import intr_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            ipl,
    input  logic [NUM_LEVELS-1:0] br,
    input  logic                  poll,
    input  logic                  ack,
    input  logic [7:0]            vec_in,
    input  logic                  taken,
    output logic [NUM_LEVELS-1:0] bg,
    output logic                  int_req,
    output logic [15:0]           int_vector,
    output logic [2:0]            int_level,
    output logic                  passive
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                r_state,   w_state_nx;
    logic [NUM_LEVELS-1:0] r_bg,      w_bg_nx;
    logic                  r_int_req, w_int_req_nx;
    logic [7:0]            r_vec,     w_vec_nx;
    logic [2:0]            r_level,   w_level_nx;
    logic                  r_passive, w_passive_nx;
    logic [CNT_W-1:0]      r_cnt,     w_cnt_nx;

    logic [NUM_LEVELS-1:0] w_win_onehot;
    logic                  w_win_any;
    logic [2:0]            w_win_index;

    intr_prio_encoder u_prio (
        .i_ipl    (ipl),
        .i_br     (br),
        .o_onehot (w_win_onehot),
        .o_any    (w_win_any),
        .o_index  (w_win_index)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_bg_nx      = r_bg;
        w_int_req_nx = r_int_req;
        w_vec_nx     = r_vec;
        w_level_nx   = r_level;
        w_cnt_nx     = r_cnt;
        w_passive_nx = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (poll && w_win_any) begin
                    w_bg_nx    = w_win_onehot;
                    w_level_nx = w_win_index;
                    w_cnt_nx   = '0;
                    w_state_nx = GRANT;
                end
            end
            GRANT: begin
                // An answer in the last timeout cycle still wins.
                if (ack) begin
                    w_vec_nx     = vec_in;
                    w_bg_nx      = '0;
                    w_int_req_nx = 1'b1;
                    w_state_nx   = PRESENT;
                end else if (r_cnt == CNT_LAST) begin
                    w_bg_nx      = '0;
                    w_passive_nx = 1'b1;
                    w_state_nx   = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            PRESENT: begin
                if (taken) begin
                    w_int_req_nx = 1'b0;
                    w_state_nx   = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bg      <= '0;
            r_int_req <= 1'b0;
            r_vec     <= '0;
            r_level   <= '0;
            r_passive <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_bg      <= w_bg_nx;
            r_int_req <= w_int_req_nx;
            r_vec     <= w_vec_nx;
            r_level   <= w_level_nx;
            r_passive <= w_passive_nx;
            r_cnt     <= w_cnt_nx;
        end
    end

    assign bg         = r_bg;
    assign int_req    = r_int_req;
    assign int_vector = {6'b0, r_vec, 2'b00};
    assign int_level  = r_level;
    assign passive    = r_passive;

endmodule

// File: tb/tb_intr_sequencer.sv
// Directed self-checking bench for intr_sequencer with TIMEOUT = 15.
module tb_intr_sequencer;

    logic        clk;
    logic        reset_n;
    logic [2:0]  ipl;
    logic [7:0]  br;
    logic        poll;
    logic        ack;
    logic [7:0]  vec_in;
    logic        taken;
    logic [7:0]  bg;
    logic        int_req;
    logic [15:0] int_vector;
    logic [2:0]  int_level;
    logic        passive;

    int tests_run    = 0;
    int tests_failed = 0;

    intr_sequencer #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ipl        (ipl),
        .br         (br),
        .poll       (poll),
        .ack        (ack),
        .vec_in     (vec_in),
        .taken      (taken),
        .bg         (bg),
        .int_req    (int_req),
        .int_vector (int_vector),
        .int_level  (int_level),
        .passive    (passive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        ipl = 3'd0; br = 8'hFF; poll = 1'b1; ack = 1'b0; vec_in = 8'h00; taken = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        tests_run++; if (bg !== 8'h00) begin tests_failed++; $display("FAIL reset_bg: got %h want 00", bg); end
        tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL reset_int_req: got %b want 0", int_req); end
        tests_run++; if (int_vector !== 16'h0000) begin tests_failed++; $display("FAIL reset_int_vector: got %h want 0000", int_vector); end
        tests_run++; if (int_level !== 3'd0) begin tests_failed++; $display("FAIL reset_int_level: got %0d want 0", int_level); end
        tests_run++; if (passive !== 1'b0) begin tests_failed++; $display("FAIL reset_passive: got %b want 0", passive); end
        poll = 1'b0; br = 8'h00;
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_grant();
        ipl = 3'd4; br = 8'h60; poll = 1'b1;
        tick();
        poll = 1'b0;
        tests_run++; if (bg !== 8'h40) begin tests_failed++; $display("FAIL basic_bg: got %h want 40", bg); end
        tests_run++; if (int_level !== 3'd6) begin tests_failed++; $display("FAIL basic_level: got %0d want 6", int_level); end
        tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL basic_req_early: got %b want 0", int_req); end
        ack = 1'b1; vec_in = 8'h1D;
        tick();
        ack = 1'b0; vec_in = 8'h00;
        tests_run++; if (bg !== 8'h00) begin tests_failed++; $display("FAIL basic_bg_clear: got %h want 00", bg); end
        tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL basic_req: got %b want 1", int_req); end
        tests_run++; if (int_vector !== 16'h0074) begin tests_failed++; $display("FAIL basic_vector: got %h want 0074", int_vector); end
        repeat (2) tick();
        tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL basic_req_hold: got %b want 1", int_req); end
        taken = 1'b1;
        tick();
        taken = 1'b0;
        tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL basic_taken: got %b want 0", int_req); end
        tests_run++; if (int_vector !== 16'h0074) begin tests_failed++; $display("FAIL basic_vector_hold: got %h want 0074", int_vector); end
        tests_run++; if (int_level !== 3'd6) begin tests_failed++; $display("FAIL basic_level_hold: got %0d want 6", int_level); end
        br = 8'h00;
    endtask

    task automatic test_masked();
        int bad;
        bad = 0;
        ipl = 3'd5; br = 8'h20; poll = 1'b1;
        repeat (10) begin
            tick();
            if (bg !== 8'h00) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL masked_equal_level: %0d cycles with bg set, want 0", bad); end
        bad = 0;
        ipl = 3'd7; br = 8'hFF;
        repeat (5) begin
            tick();
            if (bg !== 8'h00) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL masked_ipl7: %0d cycles with bg set, want 0", bad); end
        ipl = 3'd0; br = 8'h01;
        tick();
        tests_run++; if (bg !== 8'h00) begin tests_failed++; $display("FAIL masked_level0: got %h want 00", bg); end
        poll = 1'b0; br = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        int high;
        ipl = 3'd0; br = 8'h02; poll = 1'b1;
        tick();
        poll = 1'b0;
        high = 0;
        while (bg == 8'h02 && passive == 1'b0 && high < 40) begin
            high++;
            tick();
        end
        tests_run++; if (high != 15) begin tests_failed++; $display("FAIL timeout_bg_cycles: got %0d want 15", high); end
        tests_run++; if (bg !== 8'h00) begin tests_failed++; $display("FAIL timeout_bg_release: got %h want 00", bg); end
        tests_run++; if (passive !== 1'b1) begin tests_failed++; $display("FAIL timeout_passive: got %b want 1", passive); end
        tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL timeout_no_req: got %b want 0", int_req); end
        tick();
        tests_run++; if (passive !== 1'b0) begin tests_failed++; $display("FAIL timeout_passive_pulse: got %b want 0", passive); end
        poll = 1'b1;
        tick();
        poll = 1'b0;
        tests_run++; if (bg !== 8'h02) begin tests_failed++; $display("FAIL timeout_regrant: got %h want 02", bg); end
        tests_run++; if (int_level !== 3'd1) begin tests_failed++; $display("FAIL timeout_regrant_level: got %0d want 1", int_level); end
        // Answer on the last cycle before release.
        repeat (14) tick();
        tests_run++; if (bg !== 8'h02) begin tests_failed++; $display("FAIL ack_late_bg: got %h want 02", bg); end
        ack = 1'b1; vec_in = 8'h3F;
        tick();
        ack = 1'b0; vec_in = 8'h00;
        tests_run++; if (passive !== 1'b0) begin tests_failed++; $display("FAIL ack_late_passive: got %b want 0", passive); end
        tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL ack_late_req: got %b want 1", int_req); end
        tests_run++; if (int_vector !== 16'h00FC) begin tests_failed++; $display("FAIL ack_late_vector: got %h want 00FC", int_vector); end
        taken = 1'b1;
        tick();
        taken = 1'b0; br = 8'h00;
        tick();
    endtask

    task automatic test_grant_commit();
        ipl = 3'd2; br = 8'h20; poll = 1'b1;
        tick();
        poll = 1'b0;
        tests_run++; if (bg !== 8'h20) begin tests_failed++; $display("FAIL commit_bg: got %h want 20", bg); end
        br = 8'hA0; ipl = 3'd7;
        repeat (3) tick();
        tests_run++; if (bg !== 8'h20) begin tests_failed++; $display("FAIL commit_bg_hold: got %h want 20", bg); end
        tests_run++; if (int_level !== 3'd5) begin tests_failed++; $display("FAIL commit_level: got %0d want 5", int_level); end
        ack = 1'b1; vec_in = 8'h01;
        tick();
        vec_in = 8'hAA;
        tick();
        ack = 1'b0;
        tests_run++; if (int_vector !== 16'h0004) begin tests_failed++; $display("FAIL commit_vector: got %h want 0004", int_vector); end
        tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL commit_req: got %b want 1", int_req); end
        taken = 1'b1;
        tick();
        taken = 1'b0; br = 8'h00; vec_in = 8'h00; ipl = 3'd0;
        tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL commit_taken: got %b want 0", int_req); end
    endtask

    task automatic test_back_to_back();
        ipl = 3'd0; br = 8'h80; poll = 1'b1;
        tick();
        poll = 1'b0;
        ack = 1'b1; vec_in = 8'h10;
        tick();
        ack = 1'b0; vec_in = 8'h00;
        tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL b2b_req: got %b want 1", int_req); end
        taken = 1'b1; poll = 1'b1;
        tick();
        taken = 1'b0;
        tests_run++; if (int_req !== 1'b0 || bg !== 8'h00) begin tests_failed++; $display("FAIL b2b_release: got req=%b bg=%h want req=0 bg=00", int_req, bg); end
        tick();
        poll = 1'b0;
        tests_run++; if (bg !== 8'h80) begin tests_failed++; $display("FAIL b2b_regrant: got %h want 80", bg); end
        tests_run++; if (int_vector !== 16'h0040) begin tests_failed++; $display("FAIL b2b_vector_hold: got %h want 0040", int_vector); end
        tests_run++; if (int_level !== 3'd7) begin tests_failed++; $display("FAIL b2b_level: got %0d want 7", int_level); end
        // The sequencer is left in GRANT for the reset test.
    endtask

    task automatic test_async_reset();
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if (bg !== 8'h00) begin tests_failed++; $display("FAIL rst_grant_bg: got %h want 00", bg); end
        tests_run++; if (int_vector !== 16'h0000) begin tests_failed++; $display("FAIL rst_grant_vector: got %h want 0000", int_vector); end
        #2 reset_n = 1'b1;
        tick();
        tests_run++; if (bg !== 8'h00) begin tests_failed++; $display("FAIL rst_grant_stays_idle: got %h want 00", bg); end
        ipl = 3'd1; br = 8'h08; poll = 1'b1;
        tick();
        poll = 1'b0;
        tests_run++; if (bg !== 8'h08) begin tests_failed++; $display("FAIL rst_restart_bg: got %h want 08", bg); end
        ack = 1'b1; vec_in = 8'h55;
        tick();
        ack = 1'b0;
        tests_run++; if (int_req !== 1'b1 || int_vector !== 16'h0154) begin tests_failed++; $display("FAIL rst_present: got req=%b vec=%h want req=1 vec=0154", int_req, int_vector); end
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL rst_present_req: got %b want 0", int_req); end
        tests_run++; if (int_vector !== 16'h0000) begin tests_failed++; $display("FAIL rst_present_vector: got %h want 0000", int_vector); end
        #2 reset_n = 1'b1;
        br = 8'h10; poll = 1'b1;
        tick();
        poll = 1'b0;
        tests_run++; if (bg !== 8'h10 || int_level !== 3'd4) begin tests_failed++; $display("FAIL rst_restart2: got bg=%h lvl=%0d want bg=10 lvl=4", bg, int_level); end
        ack = 1'b1; vec_in = 8'h02;
        tick();
        ack = 1'b0;
        tests_run++; if (int_vector !== 16'h0008) begin tests_failed++; $display("FAIL rst_restart2_vector: got %h want 0008", int_vector); end
        taken = 1'b1;
        tick();
        taken = 1'b0; br = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_masked();
        test_timeout();
        test_grant_commit();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/intr_sequencer.md
# intr_sequencer

Interrupt acknowledge sequencer between the CPU control unit and the eight bus-request (BR) levels. At each instruction boundary it selects the highest requesting level strictly above the processor priority and issues a one-hot bus grant to that level. It waits for the device to acknowledge with its vector, then presents the vector to the CPU until the CPU takes it. A timeout releases the grant passively if no device answers.

## Interface
Parameters:
- TIMEOUT, 15, cycles bg may stay asserted without ack before passive release (1..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ipl  in  3  current processor priority, PSW[7:5]
- br  in  8  bus requests, bit n = level n; bit 0 can never win
- poll  in  1  CPU at instruction boundary, ready to service an interrupt
- ack  in  1  granted device accepts grant; vec_in valid in the same cycle
- vec_in  in  8  device vector >> 2 (vector = {vec_in, 2'b00})
- taken  in  1  CPU has consumed int_vector
- bg  out  8  one-hot bus grant, registered
- int_req  out  1  vector available to CPU, registered
- int_vector  out  16  {6'b0, vec_in latched, 2'b00}
- int_level  out  3  level of the current/last grant
- passive  out  1  one-cycle pulse on timeout release

## Operation
- Reset (async, reset_n=0): state IDLE; bg=0, int_req=0, int_vector=0, int_level=0, passive=0, timeout counter=0. Effect is immediate, and it aborts any grant or presentation in progress.
- Arbitration is combinational in IDLE:
  - hot = br & mask(ipl), where mask(n) = bits above n set (mask(7) = 0).
  - Winner = highest set bit of hot.
- States:
  - IDLE:
    - On poll=1 with hot≠0: latch winner into bg and its index into int_level, clear counter, go GRANT.
    - Otherwise stay in IDLE.
    - poll with hot=0 has no effect.
  - GRANT: bg held constant; ipl and br changes are ignored (grant committed).
    - ack=1: latch vec_in into int_vector, clear bg, go PRESENT.
    - Else, counter==TIMEOUT-1: clear bg, pulse passive for 1 cycle, go IDLE.
    - Else: increment counter.
    - ack takes priority over timeout in the same cycle.
  - PRESENT: int_req=1.
    - On taken=1: int_req=0, go IDLE.
    - int_vector and int_level hold until the next grant.
- ack outside GRANT is ignored. taken outside PRESENT is ignored.
- Only one grant is outstanding at any time. New requests are not sampled until the sequencer is back in IDLE.

## Timing
- poll sampled at cycle N (IDLE, hot≠0) → bg valid at N+1.
- ack at cycle M → bg=0 and int_req=1 at M+1. Minimum poll-to-int_req is 2 cycles.
- taken at cycle K → int_req=0 at K+1. The sequencer can accept poll at K+1 and assert a new bg at K+2.
- Timeout: bg asserted at cycle G with no ack → bg=0 and passive=1 at G+TIMEOUT. passive=0 at G+TIMEOUT+1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Counter width = clog2(TIMEOUT+1). The counter saturates by construction and never wraps.

## Structure
- Shared package intr_pkg holds:
  - the state enum (IDLE, GRANT, PRESENT)
  - the function ipl_mask(ipl) → 8-bit mask
  - the constant NUM_LEVELS=8
- Sub-module intr_prio_encoder: combinational (ipl, br) → one-hot winner plus any-above flag plus 3-bit index. It is instantiated once, and the rest of the block is the FSM and datapath registers.

## Test plan
- Basic grant: ipl=4, br=8'h60, poll pulse.
  - Expect bg=8'h40 and int_level=6 the next cycle.
  - ack with vec_in=8'h1D → int_req=1, int_vector=16'h0074.
  - taken → int_req=0.
- Masked request: ipl=5, br=8'h20, poll held 10 cycles → bg stays 0, state IDLE. At ipl=7 with br=8'hFF → no grant.
- Timeout: TIMEOUT=15, ipl=0, br=8'h02, poll, no ack.
  - bg=8'h02 for exactly 15 cycles.
  - passive=1 for exactly 1 cycle, then IDLE.
  - A subsequent poll re-grants the same level.
- Simultaneous events:
  - ack on the final timeout cycle → vector accepted and passive stays 0.
  - br rises to 8'h80 during GRANT of level 5 → bg unchanged at 8'h20.
- Reset mid-operation: assert reset_n=0 asynchronously (off the clock edge) while in GRANT, and again while in PRESENT. bg, int_req and int_vector must clear immediately, and the sequencer must restart cleanly from IDLE.
